seven_seg_pager: RTL and testbench



---
 rtl/seven_seg_pager.sv | 201 ++++++++++++++++++++
 tb/tb_seven_seg_pager.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_pager.sv
// Multi-page, multi-digit 7-segment controller with manual/auto page selection,
// leading-zero blanking, per-digit blinking and a registered segment output.
module seven_seg_pager #(
    parameter int DIGITS       = 4,
    parameter int PAGES        = 4,
    parameter int BLINK_TICKS  = 50,
    parameter int SCROLL_TICKS = 300
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic [PAGES*DIGITS*4-1:0]   page_data,
    input  logic [PAGES-1:0]            page_valid,
    input  logic [PAGES-1:0]            blank_lz,
    input  logic [$clog2(PAGES)-1:0]    page_sel,
    input  logic                        auto_scroll,
    input  logic [DIGITS-1:0]           blink_mask,
    output logic [DIGITS*7-1:0]         seg_out,
    output logic [$clog2(PAGES)-1:0]    page_cur,
    output logic                        page_changed
);

    localparam int PW = $clog2(PAGES);
    localparam int DW = $clog2(SCROLL_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [PW-1:0] LAST_PAGE  = PW'(PAGES - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCROLL_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        SEARCH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          page_cur_q, page_cur_d;
    logic [PW-1:0]          cand_q, cand_d;
    logic                   page_changed_q, page_changed_d;
    logic [DW-1:0]          dwell_q, dwell_d;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   blink_phase_q, blink_phase_d;
    logic [DIGITS*7-1:0]    seg_q, seg_d;
    logic                   sel_ok_s;
    logic [DIGITS*4-1:0]    cur_data_s;

    function automatic logic [6:0] font(input logic [3:0] nib);
        case (nib)
            4'h0:    font = 7'h40;
            4'h1:    font = 7'h79;
            4'h2:    font = 7'h24;
            4'h3:    font = 7'h30;
            4'h4:    font = 7'h19;
            4'h5:    font = 7'h12;
            4'h6:    font = 7'h02;
            4'h7:    font = 7'h78;
            4'h8:    font = 7'h00;
            4'h9:    font = 7'h10;
            4'hA:    font = 7'h08;
            4'hB:    font = 7'h03;
            4'hC:    font = 7'h46;
            4'hD:    font = 7'h21;
            4'hE:    font = 7'h06;
            4'hF:    font = 7'h0E;
            default: font = 7'h7F;
        endcase
    endfunction

    function automatic logic [PW-1:0] next_page(input logic [PW-1:0] p);
        return (p == LAST_PAGE) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // A manual request is honoured only for an existing, valid page that differs from the current one
    always_comb begin
        sel_ok_s = 1'b0;
        for (int p = 0; p < PAGES; p++) begin
            sel_ok_s = sel_ok_s | ((page_sel == PW'(p)) && page_valid[p] && (page_sel != page_cur_q));
        end
    end

    // Page selection FSM: manual select, auto dwell, and one-candidate-per-clock search
    always_comb begin
        state_d        = state_q;
        page_cur_d     = page_cur_q;
        cand_d         = cand_q;
        dwell_d        = dwell_q;
        page_changed_d = 1'b0;
        case (state_q)
            MANUAL: begin
                if (sel_ok_s) begin
                    page_cur_d     = page_sel;
                    page_changed_d = 1'b1;
                end else begin
                    page_cur_d     = page_cur_q;
                end
                if (auto_scroll) begin
                    state_d = AUTO;
                    dwell_d = {DW{1'b0}};
                end else begin
                    state_d = MANUAL;
                end
            end
            AUTO: begin
                if (!auto_scroll) begin
                    state_d = MANUAL;
                end else if (clk_en) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = {DW{1'b0}};
                        cand_d  = next_page(page_cur_q);
                        state_d = SEARCH;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end else begin
                    state_d = AUTO;
                end
            end
            SEARCH: begin
                if (!auto_scroll) begin
                    state_d = MANUAL;
                end else if (page_valid[cand_q]) begin
                    page_cur_d     = cand_q;
                    page_changed_d = 1'b1;
                    dwell_d        = {DW{1'b0}};
                    state_d        = AUTO;
                end else if (next_page(cand_q) == page_cur_q) begin
                    dwell_d = {DW{1'b0}};
                    state_d = AUTO;
                end else begin
                    cand_d  = next_page(cand_q);
                end
            end
            default: begin
                state_d = MANUAL;
            end
        endcase
    end

    // Blink timebase runs in every mode, paced by clk_en
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (clk_en) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = {BW{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Segment image of the current page: invalid-page blank, leading-zero run, blink, font
    always_comb begin : seg_build
        logic       lz_run;
        logic [3:0] nib;
        seg_d      = {(DIGITS*7){1'b1}};
        cur_data_s = page_data[page_cur_q*DIGITS*4 +: DIGITS*4];
        lz_run     = blank_lz[page_cur_q];
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib    = cur_data_s[d*4 +: 4];
            lz_run = lz_run && (nib == 4'h0) && (d != 0);
            if (!page_valid[page_cur_q] || lz_run || (blink_phase_q && blink_mask[d])) begin
                seg_d[d*7 +: 7] = SEG_BLANK;
            end else begin
                seg_d[d*7 +: 7] = font(nib);
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= MANUAL;
            page_cur_q     <= {PW{1'b0}};
            cand_q         <= {PW{1'b0}};
            page_changed_q <= 1'b0;
            dwell_q        <= {DW{1'b0}};
            blink_cnt_q    <= {BW{1'b0}};
            blink_phase_q  <= 1'b0;
            seg_q          <= {(DIGITS*7){1'b1}};
        end else begin
            state_q        <= state_d;
            page_cur_q     <= page_cur_d;
            cand_q         <= cand_d;
            page_changed_q <= page_changed_d;
            dwell_q        <= dwell_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            seg_q          <= seg_d;
        end
    end

    assign seg_out      = seg_q;
    assign page_cur     = page_cur_q;
    assign page_changed = page_changed_q;

endmodule

// File: tb/tb_seven_seg_pager.sv
// Bench for seven_seg_pager: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural page/display model.
module tb_seven_seg_pager;

    localparam int DIGITS = 4;
    localparam int PAGES  = 4;
    localparam int BT     = 2;
    localparam int ST     = 3;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, auto_scroll;
    logic [63:0] page_data;
    logic [3:0]  page_valid, blank_lz, blink_mask;
    logic [1:0]  page_sel;
    logic [27:0] seg_out;
    logic [1:0]  page_cur;
    logic        page_changed;

    seven_seg_pager #(.DIGITS(DIGITS), .PAGES(PAGES), .BLINK_TICKS(BT), .SCROLL_TICKS(ST)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .page_data(page_data),
        .page_valid(page_valid), .blank_lz(blank_lz), .page_sel(page_sel),
        .auto_scroll(auto_scroll), .blink_mask(blink_mask), .seg_out(seg_out),
        .page_cur(page_cur), .page_changed(page_changed)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // model state: mode 0 = manual, 1 = dwelling, 2 = searching
    int         m_mode, m_dwell, m_bcnt, m_left, m_target;
    logic       m_phase, m_chg;
    logic [1:0] m_page;
    logic [27:0] m_seg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] model_seg();
        logic [27:0] s;
        int h;
        int nib;
        s = '1;
        if (!page_valid[m_page]) return s;
        h = 0;
        for (int d = 0; d < DIGITS; d++)
            if (page_data[(int'(m_page)*DIGITS + d)*4 +: 4] != 4'h0) h = d;
        for (int d = 0; d < DIGITS; d++) begin
            nib = int'(page_data[(int'(m_page)*DIGITS + d)*4 +: 4]);
            if ((blank_lz[m_page] && d > h) || (m_phase && blink_mask[d])) s[d*7 +: 7] = 7'h7F;
            else s[d*7 +: 7] = FONT[nib];
        end
        return s;
    endfunction

    task automatic model_step();
        logic [27:0] nseg;
        if (!rst_n) begin
            m_mode = 0; m_page = 2'd0; m_chg = 1'b0; m_seg = '1;
            m_dwell = 0; m_bcnt = 0; m_phase = 1'b0; m_left = 0; m_target = -1;
            return;
        end
        nseg  = model_seg();
        m_chg = 1'b0;
        case (m_mode)
            0: begin
                if (page_valid[page_sel] && page_sel != m_page) begin
                    m_page = page_sel; m_chg = 1'b1;
                end
                if (auto_scroll) begin m_mode = 1; m_dwell = 0; end
            end
            1: begin
                if (!auto_scroll) m_mode = 0;
                else if (clk_en) begin
                    if (m_dwell == ST - 1) begin
                        // the first valid page ahead is reached after 'distance' search cycles
                        m_dwell = 0; m_mode = 2; m_left = PAGES - 1; m_target = -1;
                        for (int s = PAGES - 1; s >= 1; s--)
                            if (page_valid[(int'(m_page) + s) % PAGES]) begin
                                m_left = s; m_target = (int'(m_page) + s) % PAGES;
                            end
                    end else m_dwell++;
                end
            end
            default: begin
                if (!auto_scroll) m_mode = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_target >= 0) begin m_page = 2'(m_target); m_chg = 1'b1; end
                        m_mode = 1; m_dwell = 0;
                    end
                end
            end
        endcase
        if (clk_en) begin
            if (m_bcnt == BT - 1) begin m_bcnt = 0; m_phase = ~m_phase; end
            else m_bcnt++;
        end
        m_seg = nseg;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("seg_out", 32'(seg_out), 32'(m_seg));
            check("page_cur", 32'(page_cur), 32'(m_page));
            check("page_changed", 32'(page_changed), 32'(m_chg));
        end
    end

    task automatic check_reset_state();
        check("rst_seg", 32'(seg_out), 32'h0FFF_FFFF);
        check("rst_page", 32'(page_cur), 32'd0);
        check("rst_pulse", 32'(page_changed), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; auto_scroll = 1'b0; clk_en = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    int pq[$];
    logic [3:0] nib_r;

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; auto_scroll = 1'b0;
        page_data = {$urandom, $urandom}; page_valid = 4'($urandom); blank_lz = 4'($urandom);
        page_sel = 2'($urandom); blink_mask = 4'($urandom);
        cyc();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_en = 1'($urandom); auto_scroll = 1'($urandom);
            page_data = {$urandom, $urandom}; page_valid = 4'($urandom); page_sel = 2'($urandom);
            cyc();
            check_reset_state();
        end

        // first page after reset
        rst_n = 1'b1; clk_en = 1'b0; auto_scroll = 1'b0; blink_mask = 4'b0000; blank_lz = 4'b0000;
        page_data = 64'h0000_00A7_0000_1234; page_valid = 4'b0001; page_sel = 2'd0;
        cyc();
        check("first_seg", 32'(seg_out), 32'({7'h79, 7'h24, 7'h30, 7'h19}));

        // manual selection
        page_valid = 4'b0101; page_sel = 2'd2;
        cyc();
        check("man_page2", 32'(page_cur), 32'd2);
        check("man_pulse", 32'(page_changed), 32'd1);
        page_sel = 2'd1;
        cyc();
        check("man_pulse_end", 32'(page_changed), 32'd0);
        check("man_seg_p2", 32'(seg_out), 32'({7'h40, 7'h40, 7'h08, 7'h78}));
        cyc();
        check("man_invalid", 32'(page_cur), 32'd2);
        page_sel = 2'd0;
        cyc();
        check("man_page0", 32'(page_cur), 32'd0);

        // leading-zero blanking
        page_data[15:0] = 16'h0005; blank_lz = 4'b0001;
        cyc();
        check("lz_0005", 32'(seg_out), 32'({7'h7F, 7'h7F, 7'h7F, 7'h12}));
        page_data[15:0] = 16'h0000;
        cyc();
        check("lz_0000", 32'(seg_out), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        blank_lz = 4'b0000;
        cyc();
        check("lz_off", 32'(seg_out), 32'({7'h40, 7'h40, 7'h40, 7'h40}));

        // auto scroll with a skipped page
        do_reset();
        page_valid = 4'b1011; page_sel = 2'd0; auto_scroll = 1'b1;
        page_data = 64'h4444_3333_2222_1111;
        for (int i = 0; i < 90; i++) begin
            clk_en = (i % 4 == 3);
            cyc();
            if (page_changed) pq.push_back(int'(page_cur));
        end
        check("auto_changes", 32'(pq.size() >= 3), 32'd1);
        if (pq.size() >= 3) begin
            check("auto_seq0", 32'(pq[0]), 32'd1);
            check("auto_seq1", 32'(pq[1]), 32'd3);
            check("auto_seq2", 32'(pq[2]), 32'd0);
        end

        // blink of the two low digits
        do_reset();
        page_valid = 4'b0001; page_data = 64'h1234; blink_mask = 4'b0011; page_sel = 2'd0;
        clk_en = 1'b1; cyc(); cyc();
        clk_en = 1'b0; cyc();
        check("blink_on", 32'(seg_out), 32'({7'h79, 7'h24, 7'h7F, 7'h7F}));
        clk_en = 1'b1; cyc(); cyc();
        clk_en = 1'b0; cyc();
        check("blink_off", 32'(seg_out), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
        blink_mask = 4'b0000;

        // abort a fruitless search, then invalidate the shown page
        do_reset();
        page_valid = 4'b0001; auto_scroll = 1'b1;
        cyc();
        clk_en = 1'b1; cyc(); cyc(); cyc();
        clk_en = 1'b0; cyc();
        auto_scroll = 1'b0;
        cyc();
        check("abort_page", 32'(page_cur), 32'd0);
        check("abort_pulse", 32'(page_changed), 32'd0);
        page_valid = 4'b0000;
        cyc();
        check("invalid_blank", 32'(seg_out), 32'h0FFF_FFFF);
        check("invalid_page", 32'(page_cur), 32'd0);

        // reset in the middle of a search
        page_valid = 4'b0001; auto_scroll = 1'b1;
        cyc();
        clk_en = 1'b1; cyc(); cyc(); cyc();
        clk_en = 1'b0; cyc();
        rst_n = 1'b0; clk_en = 1'b1; page_sel = 2'($urandom);
        cyc();
        check_reset_state();
        rst_n = 1'b1; clk_en = 1'b0;

        // randomized traffic; page_valid only moves while auto scrolling is off
        for (int sg = 0; sg < 20; sg++) begin
            auto_scroll = 1'b0; rst_n = 1'b1;
            cyc(); cyc();
            page_valid = 4'($urandom); blank_lz = 4'($urandom);
            for (int k = 0; k < 16; k++) begin
                nib_r = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
                page_data[k*4 +: 4] = nib_r;
            end
            for (int i = 0; i < 150; i++) begin
                clk_en = ($urandom_range(2) == 0);
                page_sel = 2'($urandom);
                rst_n = ($urandom_range(299) != 0);
                if ($urandom_range(24) == 0) auto_scroll = ~auto_scroll;
                if ($urandom_range(9) == 0) blink_mask = 4'($urandom);
                if ($urandom_range(9) == 0) blank_lz = 4'($urandom);
                if ($urandom_range(14) == 0) page_data[$urandom_range(15)*4 +: 4] = 4'($urandom);
                if (!auto_scroll && $urandom_range(9) == 0) page_valid = 4'($urandom);
                cyc();
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
